// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int INSTR_W_DEF = 16;

  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory read bus plus the downstream IR offer handshake.
interface fetch_controller_if #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ready;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] ir;
  logic               ir_valid;
  logic               ir_ready;

  modport master (
    output mem_req, mem_addr, ir, ir_valid,
    input  mem_ready, mem_rdata, ir_ready
  );

  modport slave (
    input  mem_req, mem_addr, ir, ir_valid,
    output mem_ready, mem_rdata, ir_ready
  );
endinterface

// File: rtl/fetch_controller_instr_decode.sv
// Combinational opcode classifier: flags JMP/HLT and yields the word-aligned jump target.
module instr_decode
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic               is_jmp_o,
  output logic               is_hlt_o,
  output logic [ADDR_W-1:0]  target_o
);

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              unused_bits;

  assign opcode   = instr_i[INSTR_W-1 -: 4];
  assign operand  = instr_i[ADDR_W-1:0];
  assign is_jmp_o = (opcode == OP_JMP);
  assign is_hlt_o = (opcode == OP_HLT);
  assign target_o = {operand[ADDR_W-1:2], 2'b00};

  assign unused_bits = ^{instr_i[INSTR_W-5:ADDR_W], operand[1:0]};

endmodule

// File: rtl/fetch_controller.sv
// Fetch/decode/issue sequencer driving an external program counter and instruction memory.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc_add,
  output logic              pc_inc,
  output logic              jmp,
  output logic [ADDR_W-1:0] jmp_add,
  output logic              halted,
  fetch_controller_if.master bus
);

  state_t             state_q;
  logic [INSTR_W-1:0] ir_q;
  logic [ADDR_W-1:0]  jmp_add_q;
  logic               is_jmp;
  logic               is_hlt;
  logic [ADDR_W-1:0]  target;

  instr_decode #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_decode (
    .instr_i  (ir_q),
    .is_jmp_o (is_jmp),
    .is_hlt_o (is_hlt),
    .target_o (target)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      jmp_add_q <= '0;
    end else begin
      case (state_q)
        S_IDLE:   if (en) state_q <= S_FETCH;
        S_FETCH: begin
          if (bus.mem_ready) begin
            ir_q    <= bus.mem_rdata;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_hlt) begin
            state_q <= S_HALT;
          end else if (is_jmp) begin
            jmp_add_q <= target;
            state_q   <= en ? S_FETCH : S_IDLE;
          end else begin
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE:  if (bus.ir_ready) state_q <= en ? S_FETCH : S_IDLE;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // The PC pulses are decoded from state so the PC moves on the same edge that
  // leaves DECODE/ISSUE; mem_addr follows pc_add live so the next FETCH has no bubble.
  assign bus.mem_req  = (state_q == S_FETCH);
  assign bus.mem_addr = bus.mem_req ? pc_add : '0;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = (state_q == S_ISSUE);
  assign pc_inc       = bus.ir_valid && bus.ir_ready;
  assign jmp          = (state_q == S_DECODE) && is_jmp;
  assign jmp_add      = jmp ? target : jmp_add_q;
  assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a behavioural PC and wait-state memory.
module tb_fetch_controller;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] pc;
  logic       pc_inc;
  logic       jmp;
  logic [4:0] jmp_add;
  logic       halted;

  logic [15:0] rom [32];
  int          wait_n;
  int          wcnt;

  int n_checks;
  int n_fail;
  int n_inc, n_jmp, n_cap, n_both;

  fetch_controller_if #(.ADDR_W(5), .INSTR_W(16)) bus_if ();

  fetch_controller #(.ADDR_W(5), .INSTR_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .pc_add  (pc),
    .pc_inc  (pc_inc),
    .jmp     (jmp),
    .jmp_add (jmp_add),
    .halted  (halted),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural program counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        pc <= '0;
    else if (jmp)    pc <= jmp_add;
    else if (pc_inc) pc <= pc + 5'd4;
  end

  // Memory: ready after wait_n cycles of continuous request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (bus_if.mem_req && !bus_if.mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always_comb begin
    bus_if.mem_ready = bus_if.mem_req && (wcnt >= wait_n);
    bus_if.mem_rdata = rom[bus_if.mem_addr];
  end

  always @(posedge clk) begin
    if (pc_inc) n_inc++;
    if (jmp) n_jmp++;
    if (pc_inc && jmp) n_both++;
    if (bus_if.mem_req && bus_if.mem_ready) n_cap++;
  end

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
  endtask

  task automatic start_run(input logic en_v);
    @(negedge clk);
    rst = 1'b0; en = 1'b0; bus_if.ir_ready = 1'b1; wait_n = 0;
    @(negedge clk);
    @(negedge clk);
    n_inc = 0; n_jmp = 0; n_cap = 0;
    rst = 1'b1; en = en_v;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; bus_if.ir_ready = 1'b0; wait_n = 0;
    clear_rom();
    @(negedge clk);
    n_checks++;
    if ({bus_if.mem_req, bus_if.ir_valid, pc_inc, jmp, halted} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus_if.mem_req, bus_if.ir_valid, pc_inc, jmp, halted});
    end
    n_checks++;
    if ({bus_if.mem_addr, jmp_add, bus_if.ir} !== 26'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {bus_if.mem_addr, jmp_add, bus_if.ir});
    end
  endtask

  task automatic test_sequential();
    logic       exp_req, exp_inc;
    logic [4:0] exp_addr;
    clear_rom();
    rom[0] = 16'h1000; rom[4] = 16'h1000; rom[8] = 16'h1000; rom[12] = 16'hF000;
    start_run(1'b1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_req  = (k == 1 || k == 4 || k == 7 || k == 10);
      exp_addr = exp_req ? 5'((k - 1) / 3 * 4) : 5'd0;
      exp_inc  = (k == 3 || k == 6 || k == 9);
      n_checks++;
      if ({bus_if.mem_req, bus_if.mem_addr} !== {exp_req, exp_addr}) begin
        n_fail++;
        $display("FAIL seq_fetch k=%0d: got req=%b addr=%0d want req=%b addr=%0d",
                 k, bus_if.mem_req, bus_if.mem_addr, exp_req, exp_addr);
      end
      n_checks++;
      if ({pc_inc, bus_if.ir_valid} !== {exp_inc, exp_inc}) begin
        n_fail++;
        $display("FAIL seq_issue k=%0d: got inc=%b valid=%b want %b", k, pc_inc,
                 bus_if.ir_valid, exp_inc);
      end
      if (exp_inc) begin
        n_checks++;
        if (bus_if.ir !== 16'h1000) begin
          n_fail++;
          $display("FAIL seq_ir k=%0d: got %h want 1000", k, bus_if.ir);
        end
      end
      n_checks++;
      if (halted !== (k >= 12)) begin
        n_fail++;
        $display("FAIL seq_halted k=%0d: got %b want %b", k, halted, (k >= 12));
      end
    end
    n_checks++;
    if (n_inc != 3 || n_jmp != 0) begin
      n_fail++;
      $display("FAIL seq_pulses: got inc=%0d jmp=%0d want 3 0", n_inc, n_jmp);
    end
  endtask

  task automatic test_wait();
    clear_rom();
    rom[0] = 16'h1000;
    start_run(1'b1);
    wait_n = 4;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus_if.mem_req !== (k <= 5)) begin
        n_fail++;
        $display("FAIL wait_req k=%0d: got %b want %b", k, bus_if.mem_req, (k <= 5));
      end
      if (k <= 5) begin
        n_checks++;
        if ({bus_if.mem_addr, bus_if.mem_ready} !== {5'd0, (k == 5)}) begin
          n_fail++;
          $display("FAIL wait_hold k=%0d: got addr=%0d rdy=%b want 0 %b", k,
                   bus_if.mem_addr, bus_if.mem_ready, (k == 5));
        end
      end
      if (k == 6) begin
        n_checks++;
        if (bus_if.ir !== 16'h1000) begin
          n_fail++;
          $display("FAIL wait_ir: got %h want 1000", bus_if.ir);
        end
      end
      if (k == 7) begin
        n_checks++;
        if ({bus_if.ir_valid, pc_inc} !== 2'b11) begin
          n_fail++;
          $display("FAIL wait_issue: got %b want 11", {bus_if.ir_valid, pc_inc});
        end
      end
      if (k == 8) begin
        n_checks++;
        if ({bus_if.ir_valid, bus_if.mem_req} !== 2'b00) begin
          n_fail++;
          $display("FAIL wait_idle: got %b want 00", {bus_if.ir_valid, bus_if.mem_req});
        end
      end
      if (k == 1) en = 1'b0;
    end
    n_checks++;
    if (n_cap != 1 || n_inc != 1) begin
      n_fail++;
      $display("FAIL wait_counts: got cap=%0d inc=%0d want 1 1", n_cap, n_inc);
    end
  endtask

  task automatic test_jump();
    clear_rom();
    rom[0] = 16'hA013; rom[16] = 16'h1000;
    start_run(1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) begin
        n_checks++;
        if ({jmp, jmp_add, pc_inc, bus_if.ir_valid} !== {1'b1, 5'd16, 2'b00}) begin
          n_fail++;
          $display("FAIL jmp_pulse: got jmp=%b add=%0d inc=%b valid=%b want 1 16 0 0",
                   jmp, jmp_add, pc_inc, bus_if.ir_valid);
        end
      end
      if (k == 3) begin
        n_checks++;
        if ({bus_if.mem_req, bus_if.mem_addr} !== {1'b1, 5'd16}) begin
          n_fail++;
          $display("FAIL jmp_target_fetch: got req=%b addr=%0d want 1 16",
                   bus_if.mem_req, bus_if.mem_addr);
        end
        en = 1'b0;
      end
      if (k == 4) begin
        n_checks++;
        if ({jmp, jmp_add} !== {1'b0, 5'd16}) begin
          n_fail++;
          $display("FAIL jmp_add_hold: got jmp=%b add=%0d want 0 16", jmp, jmp_add);
        end
      end
      if (k == 6) begin
        n_checks++;
        if (bus_if.mem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL jmp_idle: got req=%b want 0", bus_if.mem_req);
        end
      end
    end
    n_checks++;
    if (n_jmp != 1 || n_inc != 1) begin
      n_fail++;
      $display("FAIL jmp_counts: got jmp=%0d inc=%0d want 1 1", n_jmp, n_inc);
    end
  endtask

  task automatic test_wrap();
    clear_rom();
    rom[0] = 16'hA01C; rom[28] = 16'h1000;
    start_run(1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 3) begin
        n_checks++;
        if (bus_if.mem_addr !== 5'd28) begin
          n_fail++;
          $display("FAIL wrap_fetch28: got %0d want 28", bus_if.mem_addr);
        end
      end
      if (k == 6) begin
        n_checks++;
        if ({bus_if.mem_req, bus_if.mem_addr} !== {1'b1, 5'd0}) begin
          n_fail++;
          $display("FAIL wrap_fetch0: got req=%b addr=%0d want 1 0",
                   bus_if.mem_req, bus_if.mem_addr);
        end
        en = 1'b0;
      end
      if (k == 8) begin
        n_checks++;
        if (bus_if.mem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL wrap_idle: got req=%b want 0", bus_if.mem_req);
        end
      end
    end
  endtask

  task automatic test_stall();
    clear_rom();
    rom[0] = 16'h1234;
    start_run(1'b1);
    bus_if.ir_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        n_checks++;
        if ({bus_if.ir_valid, bus_if.ir, pc_inc} !== {1'b1, 16'h1234, 1'b0}) begin
          n_fail++;
          $display("FAIL stall_hold k=%0d: got valid=%b ir=%h inc=%b want 1 1234 0",
                   k, bus_if.ir_valid, bus_if.ir, pc_inc);
        end
      end
    end
    bus_if.ir_ready = 1'b1;
    en = 1'b0;
    #1;
    n_checks++;
    if (pc_inc !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got inc=%b want 1", pc_inc);
    end
    @(negedge clk);
    n_checks++;
    if ({bus_if.ir_valid, pc_inc, bus_if.mem_req} !== 3'b000 || n_inc != 1) begin
      n_fail++;
      $display("FAIL stall_after: got %b inc_count=%0d want 000 1",
               {bus_if.ir_valid, pc_inc, bus_if.mem_req}, n_inc);
    end
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0] = 16'hF000;
    start_run(1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        n_checks++;
        if ({halted, bus_if.mem_req, pc_inc, jmp, bus_if.ir_valid} !== 5'b10000) begin
          n_fail++;
          $display("FAIL halt_k%0d: got %b want 10000", k,
                   {halted, bus_if.mem_req, pc_inc, jmp, bus_if.ir_valid});
        end
      end
      en = k[0];
    end
    n_checks++;
    if (n_inc != 0 || n_jmp != 0) begin
      n_fail++;
      $display("FAIL halt_pulses: got inc=%0d jmp=%0d want 0 0", n_inc, n_jmp);
    end
    rst = 1'b0; en = 1'b0;
    #1;
    n_checks++;
    if ({halted, bus_if.mem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL halt_reset: got %b want 00", {halted, bus_if.mem_req});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus_if.mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_en k=%0d: got req=%b want 0", k, bus_if.mem_req);
      end
    end
    en = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus_if.mem_req, bus_if.mem_addr} !== {1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL idle_start: got req=%b addr=%0d want 1 0", bus_if.mem_req,
               bus_if.mem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    clear_rom();
    rom[0] = 16'h1000;
    start_run(1'b1);
    wait_n = 10;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus_if.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got req=%b want 1", bus_if.mem_req);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus_if.mem_req, bus_if.mem_addr, bus_if.ir_valid, pc_inc, jmp, jmp_add, halted,
         bus_if.ir} !== 30'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got req=%b addr=%0d valid=%b inc=%b jmp=%b add=%0d hlt=%b ir=%h want all 0",
               bus_if.mem_req, bus_if.mem_addr, bus_if.ir_valid, pc_inc, jmp, jmp_add,
               halted, bus_if.ir);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (n_inc != 0 || n_jmp != 0 || n_cap != 0) begin
      n_fail++;
      $display("FAIL midrst_pulses: got inc=%0d jmp=%0d cap=%0d want 0 0 0",
               n_inc, n_jmp, n_cap);
    end
    rst = 1'b1; en = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    n_inc = 0; n_jmp = 0; n_cap = 0; n_both = 0;
    bus_if.ir_ready = 1'b1;
    test_reset();
    test_sequential();
    test_wait();
    test_jump();
    test_wrap();
    test_stall();
    test_halt();
    test_reset_mid_fetch();
    n_checks++;
    if (n_both != 0) begin
      n_fail++;
      $display("FAIL pulse_overlap: got %0d cycles with pc_inc and jmp both high want 0", n_both);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, the program-counter and memory address width.
REQ-002 SHALL have parameter INSTR_W, default 16, the instruction word width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock shared with program_counter.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  run enable; sampled in IDLE, DECODE (JMP) and ISSUE.
REQ-007 pc_add  input  ADDR_W  current PC value from program_counter.
REQ-008 pc_inc  output  1  one-cycle pulse that advances the PC by 4.
REQ-009 jmp  output  1  one-cycle pulse that loads the PC with jmp_add.
REQ-010 jmp_add  output  ADDR_W  jump target, word-aligned.
REQ-011 mem_req  output  1  instruction-memory read request.
REQ-012 mem_addr  output  ADDR_W  read address.
REQ-013 mem_ready  input  1  read data valid; completes the request.
REQ-014 mem_rdata  input  INSTR_W  instruction word.
REQ-015 ir  output  INSTR_W  instruction register.
REQ-016 ir_valid  output  1  ir holds an instruction offered downstream.
REQ-017 ir_ready  input  1  downstream accepts ir.
REQ-018 halted  output  1  HLT executed; the block is stopped.

Function
REQ-019 SHALL decode opcode = ir[INSTR_W-1:INSTR_W-4] and operand = ir[ADDR_W-1:0]; JMP = 4'hA, HLT = 4'hF, and all other opcodes are ordinary.
REQ-020 SHALL implement the FSM states IDLE, FETCH, DECODE, ISSUE and HALT.
REQ-021 IDLE: all pulses low; go to FETCH when en=1, otherwise stay.
REQ-022 FETCH: mem_req=1 and mem_addr=pc_add every cycle; on mem_ready=1, capture ir<=mem_rdata and go to DECODE; otherwise hold; en is ignored here (no abort).
REQ-023 FETCH SHALL allow mem_ready in the first FETCH cycle (minimum read latency of 0 wait cycles).
REQ-024 SHALL ignore mem_ready outside FETCH.
REQ-025 DECODE with HLT: go to HALT; ir_valid is never asserted for HLT.
REQ-026 DECODE with JMP: jmp=1 for exactly one cycle with jmp_add={operand[ADDR_W-1:2],2'b00}; then go to FETCH if en=1, else IDLE; ir_valid is not asserted.
REQ-027 DECODE with any other opcode: go to ISSUE.
REQ-028 ISSUE: ir_valid=1 and ir held stable until ir_ready=1.
REQ-029 ISSUE, on the cycle ir_ready=1: pc_inc=1 for that cycle only, ir_valid drops next cycle, then go to FETCH if en=1, else IDLE.
REQ-030 pc_inc and jmp SHALL never be high in the same cycle.
REQ-031 pc_inc and jmp SHALL each be high for at most one cycle per instruction.
REQ-032 The PC update lands on the same edge that leaves ISSUE/DECODE, so the following FETCH SHALL use the updated pc_add with no bubble.
REQ-033 Throughput with zero-wait memory and ir_ready held 1: 3 cycles per ordinary instruction, 2 cycles per JMP.
REQ-034 PC wrap-around (28+4 -> 0 at ADDR_W=5) SHALL need no special handling: fetch proceeds from address 0.
REQ-035 HALT: halted=1, mem_req=0, no pulses; stays in HALT until reset regardless of en.
REQ-036 jmp_add SHALL hold its last value when jmp=0.

Reset
REQ-037 On rst=0, immediately and asynchronously: state=IDLE, ir=0, ir_valid=0, mem_req=0, mem_addr=0, pc_inc=0, jmp=0, jmp_add=0, halted=0.
REQ-038 Reset mid-FETCH or mid-ISSUE SHALL drop the outstanding request or offer without producing any pulse.
REQ-039 After rst returns high, the first FETCH SHALL occur no earlier than the first edge with en=1.

Structure
REQ-040 The shared package fetch_pkg SHALL hold the opcode constants (OP_JMP, OP_HLT), the state encoding and default widths.
REQ-041 One sub-module is natural: instr_decode (combinational opcode classifier producing is_jmp, is_hlt and the aligned target); the FSM, IR and output registers stay in fetch_controller.

Verification
REQ-042 Reset, en=1, memory returns 16'h1000 at 0, 4, 8 with zero wait, ir_ready=1 -> pc_inc pulses every 3 cycles and ir_valid shows 16'h1000 three times.
REQ-043 mem_ready delayed 4 cycles -> mem_req and mem_addr held for 5 cycles, then exactly one ir capture.
REQ-044 Instruction 16'hA013 fetched -> jmp one cycle with jmp_add=5'd16, no pc_inc, no ir_valid, next mem_addr=16.
REQ-045 ir_ready=0 for 6 cycles in ISSUE -> ir_valid and ir stable, pc_inc=0 throughout, single pc_inc on release.
REQ-046 16'hF000 fetched -> halted=1, mem_req=0 forever, en toggling ignored; then rst=0 -> halted=0, state IDLE.
REQ-047 rst driven low mid-FETCH between clock edges -> all outputs 0 before the next edge, and no pulse is produced.
